// File: rtl/multi_unit_sched_pkg.sv
// multi_sched_pkg: shared types and constants for the multi-unit scheduler.
//   state_t     - scheduler FSM states
//   OWNER_W     - owner index width for the default requester count
//   owner_width - owner index width for any requester count (min 1 bit)
package multi_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int OWNER_W     = $clog2(NUM_REQ_DEF);

  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_unit_sched_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    in  NUM_REQ  request levels
//   ptr    in  OW       highest-priority index this round
//   onehot out NUM_REQ  first set req bit at or above ptr, wrapping to 0
//   idx    out OW       index of that bit
//   any    out 1        some request is set
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int OW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [OW-1:0]      idx,
  output logic               any
);

  // Walk ptr, ptr+1, ... modulo NUM_REQ; one extra bit keeps the sum from
  // overflowing before the wrap subtraction (works for non-power-of-2 counts).
  logic [OW:0]   s;
  logic [OW-1:0] j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    s      = '0;
    j      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s = {1'b0, ptr} + (OW+1)'(i);
      if (s >= (OW+1)'(NUM_REQ)) s = s - (OW+1)'(NUM_REQ);
      j = s[OW-1:0];
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = j;
      end
    end
  end

endmodule

// File: rtl/multi_unit_sched.sv
// multi_unit_sched: shares one start/done multi-cycle unit among NUM_REQ
// requesters, round-robin, one operation in flight, with a done watchdog.
//   clock, reset           clock; synchronous active-high reset
//   req, req_data          per-requester request level and operand slices
//   grant                  one-hot current owner (ISSUE..RESP)
//   rsp_valid              one-cycle response pulse to the owner
//   rsp_data, rsp_err      result / timeout flag, held until next response
//   unit_start, unit_inp   start pulse and operand to the shared unit
//   unit_done, unit_out    completion and result from the unit
//   busy                   FSM not idle
//   timeout_err            sticky: some operation has timed out since reset
module multi_unit_sched
  import multi_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic                     unit_start,
  output logic [WIDTH-1:0]         unit_inp,
  input  logic                     unit_done,
  input  logic [WIDTH-1:0]         unit_out,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int OW  = owner_width(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t             state, state_nx;
  logic [OW-1:0]      owner, ptr, pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               pick_any;
  logic [WDW-1:0]     wdog;
  logic               timed_out;
  logic [WIDTH-1:0]   operand;

  rr_pick #(.NUM_REQ(NUM_REQ), .OW(OW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // wdog counts 0..TIMEOUT-1 across WAIT, so WAIT lasts exactly TIMEOUT cycles.
  assign timed_out = (wdog == WDW'(TIMEOUT - 1));

  always_comb begin
    operand = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (owner == OW'(i)) operand = req_data[i*WIDTH +: WIDTH];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_any) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (unit_done || timed_out) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign unit_start = (state == ISSUE);
  assign unit_inp   = unit_start ? operand : '0;
  // grant is one-hot on the owner throughout RESP, so it doubles as the pulse.
  assign rsp_valid  = (state == RESP) ? grant : '0;
  assign busy       = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= '0;
      ptr         <= '0;
      wdog        <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (pick_any) begin
          grant <= pick_oh;
          owner <= pick_idx;
        end
        ISSUE: wdog <= '0;
        WAIT: begin
          // done has priority over a coincident watchdog expiry
          if (unit_done) begin
            rsp_data <= unit_out;
            rsp_err  <= 1'b0;
          end else if (timed_out) begin
            rsp_data    <= '0;
            rsp_err     <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          ptr   <= (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          grant <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_unit_sched.sv
// Directed bench for multi_unit_sched: acts as requesters and as the shared
// unit. Inputs change and outputs are sampled on the falling clock edge.
module tb_multi_unit_sched;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 15;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant, rsp_valid;
  logic [W-1:0]   rsp_data, unit_inp, unit_out;
  logic           rsp_err, unit_start, unit_done, busy, timeout_err;

  int errors = 0;
  int checks = 0;

  multi_unit_sched #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .unit_start  (unit_start),
    .unit_inp    (unit_inp),
    .unit_done   (unit_done),
    .unit_out    (unit_out),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation for requester own: wait for the start pulse, then either
  // complete after dly WAIT cycles with result res, or let the watchdog fire.
  task automatic run_op(input int own, input int dly, input logic [W-1:0] res,
                        input bit tmo, input bit spur, input bit drop);
    int           n;
    logic [N-1:0] oh;
    logic [W-1:0] ed;
    oh = 4'b0001 << own;
    ed = req_data[own*W +: W];
    n  = 0;
    while (!unit_start && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("start_seen", 64'(unit_start), 64'd1);
    chk("grant_issue", 64'(grant), 64'(oh));
    chk("unit_inp", 64'(unit_inp), 64'(ed));
    chk("busy_issue", 64'(busy), 64'd1);
    if (spur) unit_done = 1'b1;
    if (tmo) begin
      repeat (TO) begin
        @(negedge clock);
        unit_done = 1'b0;
      end
      chk("tmo_not_early", 64'(rsp_valid), 64'd0);
      chk("tmo_busy", 64'(busy), 64'd1);
      @(negedge clock);
      chk("tmo_rsp_valid", 64'(rsp_valid), 64'(oh));
      chk("tmo_rsp_err", 64'(rsp_err), 64'd1);
      chk("tmo_rsp_data", 64'(rsp_data), 64'd0);
      chk("tmo_sticky", 64'(timeout_err), 64'd1);
    end else begin
      for (int k = 0; k < dly; k++) begin
        @(negedge clock);
        unit_done = 1'b0;
        chk("no_rsp_wait", 64'(rsp_valid), 64'd0);
        chk("start_once", 64'(unit_start), 64'd0);
        chk("inp_zero", 64'(unit_inp), 64'd0);
      end
      unit_done = 1'b1;
      unit_out  = res;
      @(negedge clock);
      unit_done = 1'b0;
      chk("rsp_valid", 64'(rsp_valid), 64'(oh));
      chk("rsp_data", 64'(rsp_data), 64'(res));
      chk("rsp_err", 64'(rsp_err), 64'd0);
    end
    chk("grant_resp", 64'(grant), 64'(oh));
    if (drop) req[own] = 1'b0;
    @(negedge clock);
    chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    chk("rsp_hold", 64'(rsp_data), tmo ? 64'd0 : 64'(res));
    chk("grant_clear", 64'(grant), 64'd0);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_start"}, 64'(unit_start), 64'd0);
    chk({tag, "_inp"}, 64'(unit_inp), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_tmo"}, 64'(timeout_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req       = '0;
    unit_done = 1'b0;
    unit_out  = '0;
    req_data  = {32'h33334444, 32'hDEADBEEF, 32'h22221111, 32'h11110000};
    repeat (2) @(negedge clock);
    check_idle_zero("reset");
    reset = 1'b0;

    // single request from requester 2, done 3 cycles after start
    req = 4'b0100;
    run_op(2, 3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);

    // pointer now 3: requesters 0 and 1 -> 0 first (wrap), then 1
    req = 4'b0011;
    run_op(0, 2, 32'hA0A0A0A0, 1'b0, 1'b0, 1'b1);
    run_op(1, 1, 32'hB1B1B1B1, 1'b0, 1'b0, 1'b1);

    // spurious done while idle
    unit_done = 1'b1;
    @(negedge clock);
    unit_done = 1'b0;
    chk("spur_idle_busy", 64'(busy), 64'd0);
    chk("spur_idle_rsp", 64'(rsp_valid), 64'd0);
    // spurious done during ISSUE, real done later
    req = 4'b1000;
    run_op(3, 2, 32'hC3C3C3C3, 1'b0, 1'b1, 1'b1);

    // watchdog abort for requester 1, then normal service for requester 0
    req = 4'b0010;
    run_op(1, 0, '0, 1'b1, 1'b0, 1'b1);
    req = 4'b0001;
    run_op(0, 4, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b1);
    chk("tmo_still_set", 64'(timeout_err), 64'd1);

    // reset while in WAIT abandons the op
    req = 4'b0100;
    run_op_start_only();
    @(negedge clock);
    @(negedge clock);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    req   = '0;
    check_idle_zero("midreset");
    @(negedge clock);
    chk("post_reset_no_rsp", 64'(rsp_valid), 64'd0);
    chk("post_reset_idle", 64'(busy), 64'd0);
    req = 4'b1010;
    run_op(1, 2, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b1);
    req = '0;

    // fairness: all requesting continuously from pointer 0
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    req = 4'b1111;
    run_op(0, 1, 32'h00000010, 1'b0, 1'b0, 1'b0);
    run_op(1, 1, 32'h00000011, 1'b0, 1'b0, 1'b0);
    run_op(2, 1, 32'h00000012, 1'b0, 1'b0, 1'b0);
    run_op(3, 1, 32'h00000013, 1'b0, 1'b0, 1'b0);
    run_op(0, 1, 32'h00000014, 1'b0, 1'b0, 1'b0);
    req = '0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Wait (bounded) for the start pulse of an op that will be interrupted.
  task automatic run_op_start_only();
    int n;
    n = 0;
    while (!unit_start && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("rst_start_seen", 64'(unit_start), 64'd1);
    chk("rst_grant", 64'(grant), 64'b0100);
  endtask

endmodule
